// File: rtl/core_run_controller.sv
// Run controller for one or more cores: holds core reset after start, runs the
// cores for a bounded cycle budget, and reports done/timeout with cycle and retire counts.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start, cores held in reset
// S_HOLD    | start accepted, core reset held for HOLD_CYCLES cycles
// S_RUN     | cores released, counting cycles/retires, collecting halts
// S_DONE    | every core halted, cores frozen, results held
// S_TIMEOUT | cycle budget exhausted before all halted, results held
module core_run_controller #(
    parameter int NUM_CORES   = 1,
    parameter int HOLD_CYCLES = 2,
    parameter int MAX_CYCLES  = 1024,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] halt_i,
    input  logic [NUM_CORES-1:0] retire_i,
    output logic [NUM_CORES-1:0] core_rst_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [NUM_CORES-1:0] halted_mask_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     retire_cnt_o
);

    localparam int                HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [NUM_CORES-1:0] halted_mask;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [CNT_W-1:0]     retire_cnt;
    logic [CNT_W-1:0]     retire_inc;
    logic                 launch;
    logic                 all_halted;
    logic                 budget_hit;

    logic [NUM_CORES-1:0] core_rst_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic                 timeout_nxt;
    logic [NUM_CORES-1:0] core_rst_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 timeout_q;

    assign launch     = start && (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
    assign all_halted = &(halted_mask | halt_i);
    assign budget_hit = (cycle_cnt == LAST_CYCLE);

    // Retires from cores already marked halted are not counted.
    always_comb begin
        retire_inc = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            retire_inc = retire_inc + CNT_W'(retire_i[i] & ~halted_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == '0) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (all_halted)      state_nxt = S_DONE;
                else if (budget_hit) state_nxt = S_TIMEOUT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_rst_nxt = '1;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            S_HOLD:    busy_nxt = 1'b1;
            S_RUN: begin
                core_rst_nxt = '0;
                busy_nxt     = 1'b1;
            end
            S_DONE:    done_nxt    = 1'b1;
            S_TIMEOUT: timeout_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_q <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            core_rst_q <= core_rst_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    // Hold timer is a down-counter; HOLD ends on terminal count zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            halted_mask <= '0;
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
        end else if (launch) begin
            hold_cnt    <= HOLD_LOAD;
            halted_mask <= '0;
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
        end else if (state == S_HOLD) begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end else if (state == S_RUN) begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            halted_mask <= halted_mask | halt_i;
            retire_cnt  <= retire_cnt + retire_inc;
        end
    end

    assign core_rst_o    = core_rst_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign halted_mask_o = halted_mask;
    assign cycle_cnt_o   = cycle_cnt;
    assign retire_cnt_o  = retire_cnt;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller: a behavioural run model pushes the
// expected end-of-run results to a scoreboard, popped when the run flag appears.
module tb_core_run_controller;

    localparam int NC   = 4;
    localparam int HOLD = 2;
    localparam int MAXC = 8;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NC-1:0] halt_i;
    logic [NC-1:0] retire_i;
    logic [NC-1:0] core_rst_o;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;
    logic [NC-1:0] halted_mask_o;
    logic [CW-1:0] cycle_cnt_o;
    logic [CW-1:0] retire_cnt_o;

    typedef struct packed {
        logic [2:0]    flags;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ret;
        logic [NC-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    core_run_controller #(
        .NUM_CORES  (NC),
        .HOLD_CYCLES(HOLD),
        .MAX_CYCLES (MAXC),
        .CNT_W      (CW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt_i       (halt_i),
        .retire_i     (retire_i),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .halted_mask_o(halted_mask_o),
        .cycle_cnt_o  (cycle_cnt_o),
        .retire_cnt_o (retire_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one launch; h0..h3 are the RUN cycles on which each core pulses halt (0 = never).
    task automatic run_scenario(input string name, input int h0, input int h1, input int h2,
                                input int h3, input logic [NC-1:0] rpat);
        int            hc[NC];
        logic [NC-1:0] m;
        logic [NC-1:0] hk;
        logic [CW-1:0] r;
        logic [2:0]    fl;
        logic [NC-1:0] mexp[MAXC+1];
        int            endk;
        bit            seen;
        exp_t          e;

        hc   = '{h0, h1, h2, h3};
        m    = '0;
        r    = '0;
        fl   = 3'b000;
        endk = 0;
        for (int k = 0; k <= MAXC; k++) mexp[k] = '0;
        for (int k = 1; k <= MAXC && endk == 0; k++) begin
            mexp[k] = m;
            for (int c = 0; c < NC; c++) begin
                hk[c] = (hc[c] == k);
                if (rpat[c] && !m[c]) r = r + 1'b1;
            end
            m = m | hk;
            if (m == '1) begin
                fl   = 3'b010;
                endk = k;
            end else if (k == MAXC) begin
                fl   = 3'b001;
                endk = k;
            end
        end
        e.flags = fl;
        e.cyc   = CW'(endk);
        e.ret   = r;
        e.mask  = m;
        sb.push_back(e);

        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (HOLD - 1) @(negedge clk);
        for (int k = 1; k <= endk; k++) begin
            @(negedge clk);
            check({name, "/flags_run"}, 32'({busy_o, done_o, timeout_o}), 32'b100);
            check({name, "/core_rst_run"}, 32'(core_rst_o), (k == 1) ? 32'hF : 32'h0);
            check({name, "/cycle_run"}, 32'(cycle_cnt_o), 32'(k - 1));
            check({name, "/mask_run"}, 32'(halted_mask_o), 32'(mexp[k]));
            for (int c = 0; c < NC; c++) hk[c] = (hc[c] == k);
            halt_i   = hk;
            retire_i = rpat;
            start    = (k == 2);
        end
        @(negedge clk);
        halt_i   = '0;
        retire_i = '0;
        start    = 1'b0;

        seen = 1'b0;
        for (int w = 0; w < 8 && !seen; w++) begin
            if (done_o || timeout_o) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, "/flag_wait"}, 32'(seen), 32'd1);

        e = sb.pop_front();
        check({name, "/flags_end"}, 32'({busy_o, done_o, timeout_o}), 32'(e.flags));
        check({name, "/cycle_end"}, 32'(cycle_cnt_o), 32'(e.cyc));
        check({name, "/retire_end"}, 32'(retire_cnt_o), 32'(e.ret));
        check({name, "/mask_end"}, 32'(halted_mask_o), 32'(e.mask));
        check({name, "/core_rst_end"}, 32'(core_rst_o), 32'hF);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        halt_i   = '0;
        retire_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/core_rst", 32'(core_rst_o), 32'hF);
        check("reset/flags", 32'({busy_o, done_o, timeout_o}), 32'b000);
        check("reset/cycle", 32'(cycle_cnt_o), 32'd0);
        check("reset/retire", 32'(retire_cnt_o), 32'd0);
        check("reset/mask", 32'(halted_mask_o), 32'd0);

        // Idle with halt/retire active: nothing may move.
        rst      = 1'b0;
        halt_i   = '1;
        retire_i = '1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle/flags", 32'({busy_o, done_o, timeout_o}), 32'b000);
            check("idle/retire", 32'(retire_cnt_o), 32'd0);
        end
        check("idle/mask", 32'(halted_mask_o), 32'd0);
        check("idle/core_rst", 32'(core_rst_o), 32'hF);
        halt_i   = '0;
        retire_i = '0;

        run_scenario("halt5",    5, 5, 5, 5, 4'b0001);
        run_scenario("timeout",  0, 0, 0, 0, 4'b0011);
        run_scenario("halt_max", 8, 8, 8, 8, 4'b1000);
        run_scenario("multi",    2, 4, 4, 7, 4'b1111);

        // Reset during the third RUN cycle.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (HOLD - 1) @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            retire_i = '1;
            halt_i   = (k == 1) ? 4'b0010 : 4'b0000;
            rst      = (k == 3);
        end
        @(negedge clk);
        rst      = 1'b0;
        retire_i = '0;
        halt_i   = '0;
        check("midrst/core_rst", 32'(core_rst_o), 32'hF);
        check("midrst/flags", 32'({busy_o, done_o, timeout_o}), 32'b000);
        check("midrst/cycle", 32'(cycle_cnt_o), 32'd0);
        check("midrst/retire", 32'(retire_cnt_o), 32'd0);
        check("midrst/mask", 32'(halted_mask_o), 32'd0);

        run_scenario("relaunch", 1, 3, 2, 6, 4'b0101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
